// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared core configuration: ROB sizing, ROB entry type codes and the
//   architectural register-file geometry. reg_file draws its default ROB tag
//   width and its register geometry from here.
package reg_file_pkg;

  // ROB sizing; tags are ROB_SIZE_BIT wide and wrap at ROB_SIZE.
  localparam int ROB_SIZE_BIT = 5;
  localparam int ROB_SIZE     = 1 << ROB_SIZE_BIT;

  // ROB entry kinds (register write, store, branch).
  typedef enum logic [1:0] {
    ROB_REG = 2'd0,
    ROB_ST  = 2'd1,
    ROB_BR  = 2'd2
  } rob_type_e;

  // Architectural register file geometry.
  localparam int XLEN     = 32;
  localparam int REG_NUM  = 32;
  localparam int REG_ID_W = 5;

endpackage

// File: rtl/reg_file.sv
// reg_file
//   Architectural register file with rename (busy/tag) tracking for a
//   ROB-based out-of-order core. Each register holds a committed value, a
//   busy bit and the ROB tag of its newest in-flight producer.
//
// Ports
//   clk_in                      system clock, rising edge
//   rst_in                      asynchronous active-high reset
//   rdy_in                      global stall: low holds all state, no forwarding
//   rob_clear                   misprediction flush (clears every busy bit/tag)
//   is_update_val/_id/_dep/val  commit from ROB head (value write, busy release)
//   is_update_dep/_dep_id/_dep  rename from ROB tail (mark busy, record tag)
//   qry1_id, qry2_id            source register indices from the decoder
//   qryN_value/_has_dep/_dep    combinational operand lookup with commit forwarding
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ROB_SIZE_BIT = reg_file_pkg::ROB_SIZE_BIT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic                    is_update_val,
  input  logic [REG_ID_W-1:0]     update_val_id,
  input  logic [ROB_SIZE_BIT-1:0] update_val_dep,
  input  logic [XLEN-1:0]         update_val,
  input  logic                    is_update_dep,
  input  logic [REG_ID_W-1:0]     update_dep_id,
  input  logic [ROB_SIZE_BIT-1:0] update_dep,
  input  logic [REG_ID_W-1:0]     qry1_id,
  input  logic [REG_ID_W-1:0]     qry2_id,
  output logic [XLEN-1:0]         qry1_value,
  output logic                    qry1_has_dep,
  output logic [ROB_SIZE_BIT-1:0] qry1_dep,
  output logic [XLEN-1:0]         qry2_value,
  output logic                    qry2_has_dep,
  output logic [ROB_SIZE_BIT-1:0] qry2_dep
);

  typedef struct packed {
    logic [XLEN-1:0]         value;
    logic                    has_dep;
    logic [ROB_SIZE_BIT-1:0] dep;
  } qry_t;

  logic [XLEN-1:0]         value_q [REG_NUM];
  logic [REG_NUM-1:0]      busy_q;
  logic [ROB_SIZE_BIT-1:0] tag_q   [REG_NUM];

  logic commit_en;
  logic issue_en;

  // x0 is hardwired: neither commits nor renames ever touch it.
  assign commit_en = rdy_in && is_update_val && (update_val_id != '0);
  assign issue_en  = rdy_in && is_update_dep && (update_dep_id != '0);

  // NOTE: the whole array is reset here on purpose -- after reset every query
  // must read 0, so the value storage cannot be left as uninitialised RAM.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (commit_en) begin
        value_q[update_val_id] <= update_val;
        // Only release the register if no younger rename has replaced the tag.
        if (tag_q[update_val_id] == update_val_dep)
          busy_q[update_val_id] <= 1'b0;
      end
      // Later assignments override the commit's busy release, so a same-cycle
      // rename (or a flush) wins over the commit for busy and tag.
      if (rob_clear) begin
        busy_q <= '0;
        for (int i = 0; i < REG_NUM; i++)
          tag_q[i] <= '0;
      end else if (issue_en) begin
        busy_q[update_dep_id] <= 1'b1;
        tag_q[update_dep_id]  <= update_dep;
      end
    end
  end

  // Operand lookup against pre-edge state. A busy register whose producer is
  // committing this very cycle is satisfied directly from the commit bus.
  function automatic qry_t query_mux(input logic [REG_ID_W-1:0] id);
    qry_t r;
    r = '0;
    if (id != '0) begin
      r.value = value_q[id];
      if (busy_q[id]) begin
        if (rdy_in && is_update_val && (tag_q[id] == update_val_dep)) begin
          r.value = update_val;
        end else begin
          r.has_dep = 1'b1;
          r.dep     = tag_q[id];
        end
      end
    end
    return r;
  endfunction

  // NOTE: pure combinational decode in always_comb with blocking assignments;
  // every output is assigned on every path, so no latch can be inferred.
  always_comb begin
    {qry1_value, qry1_has_dep, qry1_dep} = query_mux(qry1_id);
    {qry2_value, qry2_has_dep, qry2_dep} = query_mux(qry2_id);
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file
//   Self-checking bench for reg_file: directed scenarios for the documented
//   corner cases followed by randomized traffic compared against an
//   array-based reference model of the register/rename rules.
module tb_reg_file;

  localparam int RB = 5;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          rob_clear;
  logic          is_update_val;
  logic [4:0]    update_val_id;
  logic [RB-1:0] update_val_dep;
  logic [31:0]   update_val;
  logic          is_update_dep;
  logic [4:0]    update_dep_id;
  logic [RB-1:0] update_dep;
  logic [4:0]    qry1_id;
  logic [4:0]    qry2_id;
  logic [31:0]   qry1_value;
  logic          qry1_has_dep;
  logic [RB-1:0] qry1_dep;
  logic [31:0]   qry2_value;
  logic          qry2_has_dep;
  logic [RB-1:0] qry2_dep;

  reg_file #(.ROB_SIZE_BIT(RB)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .rob_clear     (rob_clear),
    .is_update_val (is_update_val),
    .update_val_id (update_val_id),
    .update_val_dep(update_val_dep),
    .update_val    (update_val),
    .is_update_dep (is_update_dep),
    .update_dep_id (update_dep_id),
    .update_dep    (update_dep),
    .qry1_id       (qry1_id),
    .qry2_id       (qry2_id),
    .qry1_value    (qry1_value),
    .qry1_has_dep  (qry1_has_dep),
    .qry1_dep      (qry1_dep),
    .qry2_value    (qry2_value),
    .qry2_has_dep  (qry2_has_dep),
    .qry2_dep      (qry2_dep)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural view of each register.
  logic [31:0]   m_val  [32];
  bit            m_busy [32];
  logic [RB-1:0] m_tag  [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i]  = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  // What a decoder should see for register id given the current inputs.
  function automatic void model_query(input logic [4:0] id, output logic [31:0] v,
                                      output logic hd, output logic [RB-1:0] d);
    v = '0; hd = 1'b0; d = '0;
    if (id == 0) return;
    v = m_val[id];
    if (!m_busy[id]) return;
    if (rdy_in && is_update_val && m_tag[id] == update_val_dep) begin
      v = update_val;
      return;
    end
    hd = 1'b1;
    d  = m_tag[id];
  endfunction

  // Effect of one rising edge on the architectural state.
  task automatic model_edge();
    if (rst_in) begin
      model_reset();
      return;
    end
    if (!rdy_in) return;
    if (is_update_val && update_val_id != 0) begin
      m_val[update_val_id] = update_val;
      if (m_tag[update_val_id] == update_val_dep) m_busy[update_val_id] = 1'b0;
    end
    if (rob_clear) begin
      for (int i = 0; i < 32; i++) begin
        m_busy[i] = 1'b0;
        m_tag[i]  = '0;
      end
    end else if (is_update_dep && update_dep_id != 0) begin
      m_busy[update_dep_id] = 1'b1;
      m_tag[update_dep_id]  = update_dep;
    end
  endtask

  task automatic idle();
    rdy_in         = 1'b1;
    rob_clear      = 1'b0;
    is_update_val  = 1'b0;
    update_val_id  = '0;
    update_val_dep = '0;
    update_val     = '0;
    is_update_dep  = 1'b0;
    update_dep_id  = '0;
    update_dep     = '0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    idle();
  endtask

  task automatic check_model(input string tag);
    logic [31:0]   v;
    logic          hd;
    logic [RB-1:0] d;
    #1;
    model_query(qry1_id, v, hd, d);
    check({tag, "_q1_val"}, qry1_value, v);
    check({tag, "_q1_hd"}, {31'd0, qry1_has_dep}, {31'd0, hd});
    check({tag, "_q1_dep"}, {27'd0, qry1_dep}, {27'd0, d});
    model_query(qry2_id, v, hd, d);
    check({tag, "_q2_val"}, qry2_value, v);
    check({tag, "_q2_hd"}, {31'd0, qry2_has_dep}, {31'd0, hd});
    check({tag, "_q2_dep"}, {27'd0, qry2_dep}, {27'd0, d});
  endtask

  // Constant expectation on port 1 for one register.
  task automatic expect1(input string tag, input logic [4:0] id, input logic [31:0] v,
                         input logic hd, input logic [RB-1:0] d);
    qry1_id = id;
    #1;
    check({tag, "_val"}, qry1_value, v);
    check({tag, "_hd"}, {31'd0, qry1_has_dep}, {31'd0, hd});
    check({tag, "_dep"}, {27'd0, qry1_dep}, {27'd0, d});
  endtask

  initial begin
    idle();
    qry1_id = '0;
    qry2_id = '0;
    model_reset();
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;

    // Reset state.
    expect1("rst_x5", 5'd5, 32'h0, 1'b0, '0);
    expect1("rst_x31", 5'd31, 32'h0, 1'b0, '0);

    // Rename then commit with same-cycle forwarding.
    is_update_dep = 1'b1; update_dep_id = 5'd5; update_dep = 5'd3;
    expect1("iss_old_map", 5'd5, 32'h0, 1'b0, '0);
    tick();
    expect1("iss_x5", 5'd5, 32'h0, 1'b1, 5'd3);
    is_update_val = 1'b1; update_val_id = 5'd5; update_val_dep = 5'd3;
    update_val = 32'hDEADBEEF;
    expect1("fwd_x5", 5'd5, 32'hDEADBEEF, 1'b0, '0);
    tick();
    expect1("stored_x5", 5'd5, 32'hDEADBEEF, 1'b0, '0);

    // Younger rename survives an older commit.
    is_update_dep = 1'b1; update_dep_id = 5'd7; update_dep = 5'd2;
    tick();
    is_update_dep = 1'b1; update_dep_id = 5'd7; update_dep = 5'd9;
    tick();
    is_update_val = 1'b1; update_val_id = 5'd7; update_val_dep = 5'd2; update_val = 32'h11;
    expect1("old_commit_nofwd", 5'd7, 32'h0, 1'b1, 5'd9);
    tick();
    expect1("young_x7", 5'd7, 32'h11, 1'b1, 5'd9);

    // Same-cycle commit and issue: issue wins for busy/tag.
    is_update_val = 1'b1; update_val_id = 5'd4; update_val_dep = 5'd6; update_val = 32'h22;
    is_update_dep = 1'b1; update_dep_id = 5'd4; update_dep = 5'd10;
    tick();
    expect1("both_x4", 5'd4, 32'h22, 1'b1, 5'd10);

    // Flush with a concurrent issue.
    for (int r = 1; r <= 3; r++) begin
      is_update_dep = 1'b1; update_dep_id = 5'(r); update_dep = RB'(r + 20);
      tick();
    end
    rob_clear = 1'b1;
    is_update_dep = 1'b1; update_dep_id = 5'd8; update_dep = 5'd4;
    tick();
    expect1("flush_x1", 5'd1, 32'h0, 1'b0, '0);
    expect1("flush_x3", 5'd3, 32'h0, 1'b0, '0);
    expect1("flush_x7", 5'd7, 32'h11, 1'b0, '0);
    expect1("flush_x8", 5'd8, 32'h0, 1'b0, '0);

    // x0 is immutable.
    is_update_val = 1'b1; update_val_id = 5'd0; update_val_dep = 5'd0; update_val = 32'h55;
    is_update_dep = 1'b1; update_dep_id = 5'd0; update_dep = 5'd1;
    expect1("x0_same", 5'd0, 32'h0, 1'b0, '0);
    tick();
    expect1("x0_after", 5'd0, 32'h0, 1'b0, '0);

    // Stall: no update and no forwarding.
    is_update_dep = 1'b1; update_dep_id = 5'd6; update_dep = 5'd13;
    tick();
    rdy_in = 1'b0;
    is_update_dep = 1'b1; update_dep_id = 5'd9; update_dep = 5'd5;
    is_update_val = 1'b1; update_val_id = 5'd6; update_val_dep = 5'd13; update_val = 32'h77;
    expect1("stall_nofwd", 5'd6, 32'h0, 1'b1, 5'd13);
    tick();
    expect1("stall_x9", 5'd9, 32'h0, 1'b0, '0);
    expect1("stall_x6", 5'd6, 32'h0, 1'b1, 5'd13);

    // Asynchronous reset with x5 busy, checked before the next edge.
    is_update_dep = 1'b1; update_dep_id = 5'd5; update_dep = 5'd12;
    tick();
    expect1("pre_rst_x5", 5'd5, 32'hDEADBEEF, 1'b1, 5'd12);
    qry2_id = 5'd4;
    #1 rst_in = 1'b1;
    expect1("arst_x5", 5'd5, 32'h0, 1'b0, '0);
    check("arst_x4_val", qry2_value, 32'h0);
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] cid;
      rdy_in        = ($urandom_range(0, 9) != 0);
      rob_clear     = ($urandom_range(0, 19) == 0);
      is_update_val = $urandom_range(0, 1) == 1;
      cid           = 5'($urandom_range(0, 31));
      update_val_id = cid;
      update_val_dep = ($urandom_range(0, 2) != 0) ? m_tag[cid] : RB'($urandom);
      update_val    = $urandom;
      is_update_dep = $urandom_range(0, 1) == 1;
      update_dep_id = 5'($urandom_range(0, 31));
      update_dep    = RB'($urandom);
      qry1_id       = ($urandom_range(0, 3) == 0) ? cid : 5'($urandom_range(0, 31));
      qry2_id       = ($urandom_range(0, 3) == 0) ? update_dep_id : 5'($urandom_range(0, 31));
      check_model("rnd");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
